// File: rtl/sqw_pkg.sv
// sqw_pkg: shared types and widths for the square-wave generator.
package sqw_pkg;
  localparam int SAMPLE_W = 16;
  localparam int HP_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} sqw_state_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sqw_envelope.sv
// sqw_envelope: saturating up/down ramp counter giving the note amplitude envelope.
module sqw_envelope
  import sqw_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] STEP = 16'd64,
  parameter logic [SAMPLE_W-1:0] MAX  = 16'h2000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                up,
  input  logic                down,
  output logic [SAMPLE_W-1:0] env,
  output logic                env_zero
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) env <= '0;
    else if (tick && up) env <= (env >= MAX - STEP) ? MAX : env + STEP;
    else if (tick && down) env <= (env <= STEP) ? '0 : env - STEP;
  end
  assign env_zero = (env == '0);
endmodule

// File: rtl/square_wave_generator.sv
// square_wave_generator: half-period code to signed square-wave PCM over valid/ready.
// Define SQW_RAMP_EN to add the attack/release envelope and the RELEASE state.
module square_wave_generator
  import sqw_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] AMP = 16'sh2000
`ifdef SQW_RAMP_EN
  , parameter logic [SAMPLE_W-1:0] RAMP_STEP = 16'd64
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic [HP_W-1:0]            half_period,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       active,
  output logic                       overrun
);
  sqw_state_t state, state_n;
  logic [HP_W-1:0] cnt, cnt_n, hp_q, hp_q_n;
  logic phase, phase_n, tick_d;
  sample_t mag, next_sample;
`ifdef SQW_RAMP_EN
  logic [SAMPLE_W-1:0] env;
  logic env_zero;
  sqw_envelope #(.STEP(RAMP_STEP), .MAX(AMP)) u_env (
    .clk(clk), .rst(rst), .tick(sample_tick),
    .up(state_n == RUN), .down(state_n == RELEASE),
    .env(env), .env_zero(env_zero)
  );
  assign mag = sample_t'(env);
`else
  assign mag = AMP;
`endif
  // cnt counts samples already emitted in the current half; the boundary tick starts the next half
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hp_q_n = hp_q;
    phase_n = phase;
    if (sample_tick) begin
      if (state == IDLE) begin
        if (half_period != '0) begin
          hp_q_n = half_period;
          cnt_n = HP_W'(1);
          phase_n = 1'b0;
          state_n = RUN;
        end
      end
`ifdef SQW_RAMP_EN
      else if (state == RELEASE && env_zero) begin
        state_n = IDLE;
        cnt_n = '0;
        phase_n = 1'b0;
      end
`endif
      else if (cnt == hp_q) begin
        cnt_n = HP_W'(1);
        phase_n = ~phase;
        if (half_period != '0) begin
          hp_q_n = half_period;
          state_n = RUN;
        end else begin
`ifdef SQW_RAMP_EN
          state_n = RELEASE;
`else
          state_n = IDLE;
          phase_n = 1'b0;
          cnt_n = '0;
`endif
        end
      end else cnt_n = cnt + 1'b1;
    end
  end
  // the sample is built from the state as it stands after the tick, one clk later
  assign next_sample = (state == IDLE) ? '0 : phase ? -mag : mag;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      hp_q <= '0;
      phase <= 1'b0;
      active <= 1'b0;
      tick_d <= 1'b0;
      sample_data <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hp_q <= hp_q_n;
      phase <= phase_n;
      active <= (state_n != IDLE);
      tick_d <= sample_tick;
      overrun <= tick_d && sample_valid && !sample_ready;
      sample_valid <= tick_d || (sample_valid && !sample_ready);
      if (tick_d) sample_data <= next_sample;
    end
  end
endmodule

// File: tb/tb_square_wave_generator.sv
// tb_square_wave_generator: randomized scoreboard bench against a sample-level note model.
module tb_square_wave_generator;
  localparam int AMP = 8192;
  typedef struct {int data; int act;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_tick = 1'b0;
  logic [7:0] half_period = '0;
  logic signed [15:0] sample_data;
  logic sample_valid;
  logic sample_ready = 1'b1;
  logic active;
  logic overrun;
  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int ready_rand = 0;
  exp_t exp_q[$];
  int m_on = 0, m_level = 1, m_hp = 0, m_n = 0;

  square_wave_generator dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .half_period(half_period),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .active(active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // note model: a half lasts hp samples; the key is re-read only when a half completes
  task automatic model_tick(input int hp);
    exp_t e;
    if (m_on == 0) begin
      if (hp != 0) begin
        m_on = 1; m_level = 1; m_hp = hp; m_n = 1;
      end
    end else if (m_n < m_hp) m_n++;
    else if (hp == 0) m_on = 0;
    else begin
      m_hp = hp; m_level = -m_level; m_n = 1;
    end
    e.data = m_on ? m_level * AMP : 0;
    e.act = m_on;
    exp_q.push_back(e);
  endtask

  task automatic do_tick(input int hp, input int gap);
    @(posedge clk); #1;
    half_period = 8'(hp);
    sample_tick = 1'b1;
    model_tick(hp);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 600 && m_on != 0; i++) do_tick(0, 5);
    do_tick(0, 5);
  endtask

  // monitor: every accepted sample is checked against the oldest expectation
  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (rst && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sample", int'(sample_data), e.data);
        chk("active", int'(active), e.act);
      end
    end
  end

  initial begin
    int low_run = 0;
    forever begin
      @(posedge clk); #1;
      if (ready_rand != 0) begin
        sample_ready = (low_run >= 2) ? 1'b1 : 1'($urandom % 2);
        low_run = sample_ready ? 0 : low_run + 1;
      end
    end
  end

  initial begin
    int ov0, hp;
    exp_t e;
    #23;
    chk("rst_data", int'(sample_data), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    // first sample of a note lands exactly one clk after the tick
    @(posedge clk); #1;
    half_period = 8'd91;
    sample_tick = 1'b1;
    model_tick(91);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("lat_pre_valid", int'(sample_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid", int'(sample_valid), 1);
    chk("lat_data", int'(sample_data), AMP);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 400; i++) do_tick(91, 5);
    go_idle();
    // pitch change mid-half
    for (int i = 0; i < 40; i++) do_tick(91, 5);
    for (int i = 0; i < 200; i++) do_tick(48, 5);
    go_idle();
    // key release mid-half
    for (int i = 0; i < 10; i++) do_tick(91, 5);
    for (int i = 0; i < 90; i++) do_tick(0, 5);
    chk("release_model_idle", m_on, 0);
    // overrun: two loads with no consumption in between
    sample_ready = 1'b0;
    ov0 = ov_cnt;
    do_tick(3, 4);
    do_tick(3, 3);
    chk("overrun_count", ov_cnt - ov0, 1);
    chk("overrun_valid", int'(sample_valid), 1);
    void'(exp_q.pop_front());
    chk("overrun_data", int'(sample_data), exp_q[0].data);
    repeat (4) @(posedge clk);
    chk("overrun_hold_valid", int'(sample_valid), 1);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    repeat (4) @(posedge clk);
    // randomized pitch / key / ready traffic
    ov0 = ov_cnt;
    ready_rand = 1;
    hp = 0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom % 40 == 0) begin
        case ($urandom % 7)
          0: hp = 0;
          1: hp = 1;
          2: hp = 2;
          3: hp = 5;
          4: hp = 48;
          5: hp = 91;
          default: hp = int'($urandom_range(1, 255));
        endcase
      end
      do_tick(hp, int'($urandom_range(5, 7)));
    end
    ready_rand = 0;
    #1;
    sample_ready = 1'b1;
    repeat (4) @(posedge clk);
    chk("random_no_overrun", ov_cnt - ov0, 0);
    // asynchronous reset mid-note with a pending sample
    sample_ready = 1'b0;
    do_tick(91, 2);
    do_tick(91, 3);
    chk("pre_reset_valid", int'(sample_valid), 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_data", int'(sample_data), 0);
    chk("async_rst_valid", int'(sample_valid), 0);
    chk("async_rst_active", int'(active), 0);
    exp_q.delete();
    m_on = 0;
    #7;
    rst = 1'b1;
    sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_tick(0, 6);
    do_tick(7, 6);
    go_idle();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
